bicubic_window_feeder: RTL

- Requester-side partner of the 2x bicubic upsample core.
- Accepts a stream of 4-pixel vertical columns from the upstream line buffer and slides them into a 4x4 window register.
- Issues each full window to the upsample core over the bf_req/bcci_req handshake, collects the core's two 8-pixel response beats, and presents the resulting 4x4 output block downstream.
- Strictly serialized: one window is in flight at a time.

---
 rtl/bicubic_window_feeder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bicubic_window_feeder.sv
// bicubic_window_feeder: slides 4-pixel columns into a 4x4 window, runs one
// request/two-beat response exchange with the upsample core, emits the 4x4 block.
module bicubic_window_feeder #(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       col_valid,
  output logic                       col_ready,
  input  logic [4*CHANNEL_WIDTH-1:0] col_data,
  input  logic                       col_last,
  output logic                       bf_req_valid,
  input  logic                       bcci_req_ready,
  output logic [CHANNEL_WIDTH-1:0]   p1,
  output logic [CHANNEL_WIDTH-1:0]   p2,
  output logic [CHANNEL_WIDTH-1:0]   p3,
  output logic [CHANNEL_WIDTH-1:0]   p4,
  output logic [CHANNEL_WIDTH-1:0]   p5,
  output logic [CHANNEL_WIDTH-1:0]   p6,
  output logic [CHANNEL_WIDTH-1:0]   p7,
  output logic [CHANNEL_WIDTH-1:0]   p8,
  output logic [CHANNEL_WIDTH-1:0]   p9,
  output logic [CHANNEL_WIDTH-1:0]   p10,
  output logic [CHANNEL_WIDTH-1:0]   p11,
  output logic [CHANNEL_WIDTH-1:0]   p12,
  output logic [CHANNEL_WIDTH-1:0]   p13,
  output logic [CHANNEL_WIDTH-1:0]   p14,
  output logic [CHANNEL_WIDTH-1:0]   p15,
  output logic [CHANNEL_WIDTH-1:0]   p16,
  input  logic                       bcci_rsp_valid,
  output logic                       bf_rsp_ready,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data1,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data2,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data3,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data4,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data5,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data6,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data7,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data8,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [16*CHANNEL_WIDTH-1:0] out_data,
  output logic                       out_last,
  output logic                       proto_err
);
  localparam int CW = CHANNEL_WIDTH;
  typedef enum logic [1:0] {FILL, REQ, RSP2, OUT} state_t;
  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d, cnt_inc;
  logic [16*CW-1:0]   win_q, win_d, res_q, res_d;
  logic               last_q, last_d, err_q, err_d;
  logic [8*CW-1:0]    beat;
  assign beat = {bcci_rsp_data8, bcci_rsp_data7, bcci_rsp_data6, bcci_rsp_data5,
                 bcci_rsp_data4, bcci_rsp_data3, bcci_rsp_data2, bcci_rsp_data1};
  assign cnt_inc = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    res_d   = res_q;
    last_d  = last_q;
    err_d   = err_q;
    unique case (state_q)
      FILL: if (col_valid) begin
        win_d = {col_data, win_q[16*CW-1:4*CW]};
        if (cnt_inc == 3'd4) begin
          state_d = REQ;
          cnt_d   = 3'd4;
          last_d  = col_last;
        end else cnt_d = col_last ? 3'd0 : cnt_inc;
      end
      REQ: if (bcci_req_ready && bcci_rsp_valid) begin
        res_d[8*CW-1:0] = beat;
        state_d = RSP2;
      end
      RSP2: begin
        err_d = err_q | bcci_req_ready;
        if (bcci_rsp_valid) begin
          res_d[16*CW-1:8*CW] = beat;
          state_d = OUT;
        end
      end
      OUT: if (out_ready) begin
        state_d = FILL;
        cnt_d   = last_q ? 3'd0 : 3'd3;
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      win_q   <= '0;
      res_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      res_q   <= res_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end
  assign col_ready    = state_q == FILL;
  assign bf_req_valid = (state_q == REQ) || (state_q == RSP2);
  assign bf_rsp_ready = bf_req_valid;
  assign out_valid    = state_q == OUT;
  assign out_last     = out_valid & last_q;
  assign out_data     = res_q;
  assign proto_err    = err_q;
  assign p1  = win_q[CW*0  +: CW];
  assign p2  = win_q[CW*1  +: CW];
  assign p3  = win_q[CW*2  +: CW];
  assign p4  = win_q[CW*3  +: CW];
  assign p5  = win_q[CW*4  +: CW];
  assign p6  = win_q[CW*5  +: CW];
  assign p7  = win_q[CW*6  +: CW];
  assign p8  = win_q[CW*7  +: CW];
  assign p9  = win_q[CW*8  +: CW];
  assign p10 = win_q[CW*9  +: CW];
  assign p11 = win_q[CW*10 +: CW];
  assign p12 = win_q[CW*11 +: CW];
  assign p13 = win_q[CW*12 +: CW];
  assign p14 = win_q[CW*13 +: CW];
  assign p15 = win_q[CW*14 +: CW];
  assign p16 = win_q[CW*15 +: CW];
endmodule
